traffic_sensor_cond: RTL
========================

// Module: traffic_sensor_cond
// PURPOSE
//  Upstream conditioner for the traffic-light controller: takes raw asynchronous car-sensor inputs for
//  street A and street B, synchronises and debounces them, and drives clean Ta/Tb levels into the
//  controller. Also emits one-cycle change pulses for debug LEDs and counters.
//  Sits between the board sensor pins/switches and the controller's Ta/Tb inputs.
// PARAMETERS
//  DEB_CYCLES  4   consecutive stable cycles required before an output level changes (1 .. 2^CNT_W-1)
//  CNT_W       16  width of each debounce counter
// PORTS
//  CLK      in   1  system clock, all state on rising edge
//  Reset    in   1  asynchronous, active-high reset
//  iTa_raw  in   1  raw street-A sensor, asynchronous to CLK
//  iTb_raw  in   1  raw street-B sensor, asynchronous to CLK
//  iClrA    in   1  clear for the street-A request latch (used only with SENSOR_LATCH_EN)
//  iClrB    in   1  clear for the street-B request latch (used only with SENSOR_LATCH_EN)
//  oTa      out  1  conditioned street-A traffic present, to controller Ta
//  oTb      out  1  conditioned street-B traffic present, to controller Tb
//  oTa_chg  out  1  one-cycle pulse when the debounced A level flips
//  oTb_chg  out  1  one-cycle pulse when the debounced B level flips
// BEHAVIOUR
//  - Reset (async assert): sync flops, debounced levels, counters and latches go to 0.
//    oTa = oTb = oTa_chg = oTb_chg = 0. Reset release is not synchronised here; it comes in clean.
//  - Per channel, the raw input passes through a 2-flop synchroniser (s1 -> s2).
//  - Debounce: each cycle, s2 is compared with the debounced level deb.
//    * s2 == deb: the counter clears to 0.
//    * s2 != deb and cnt < DEB_CYCLES-1: cnt increments.
//    * s2 != deb and cnt == DEB_CYCLES-1: deb <= s2, cnt <= 0, chg pulses high for exactly the
//      next cycle.
//  - Latency: a raw step held stable reaches deb on rising edge 2+DEB_CYCLES after it is applied.
//  - Glitch rejection: any raw pulse shorter than DEB_CYCLES cycles, measured at s2, never changes deb.
//    A mismatch run broken by even one matching cycle restarts the count from 0.
//  - The channels are fully independent; simultaneous flips on A and B both pulse in the same cycle.
//  - The counter never exceeds DEB_CYCLES-1, so there is no wrap. DEB_CYCLES=1 flips one cycle after
//    the first mismatch.
//  - Reset mid-count discards the partial count; after release, debounce restarts from deb=0.
// CONFIGURATION
//  SENSOR_LATCH_EN defined:
//    - A per-channel request latch is set on a deb rising edge (0->1).
//    - The latch is cleared by iClrA / iClrB. If set and clear occur in the same cycle, set wins.
//    - oTa = debA | latchA, and the same for B. A car that leaves before service is still reported.
//  SENSOR_LATCH_EN undefined:
//    - No latch flops. oTa = debA and oTb = debB. iClrA / iClrB are ignored.
//  - oT*_chg always reflects the debounced level only, never the latch.
// STRUCTURE
//  - Package tl_pkg holds the DEB_CYCLES and CNT_W defaults and shared light/sensor encodings
//    (GREEN/YELLOW/RED codes) used by the controller and the display stage.
//  - One sub-module, sensor_debounce: sync + counter + chg pulse for one channel,
//    instantiated twice (A, B).
//  - The optional latch and output OR sit in the top level.
// TESTING (DEB_CYCLES=4 unless noted)
//  1. Reset held, toggle iTa_raw/iTb_raw -> all outputs stay 0. Release with raw=0 -> outputs stay 0.
//  2. iTa_raw 0->1 held -> oTa=1 on edge 6 after the step, oTa_chg=1 for exactly that one cycle.
//     oTb stays 0.
//  3. iTb_raw 3-cycle high pulse -> oTb never rises, oTb_chg never pulses.
//     Then a 4-cycle pulse -> oTb rises, and falls 6 edges after the raw fall.
//  4. Both raw inputs step together -> oTa/oTb rise in the same cycle, both chg pulses coincide.
//  5. Assert Reset at 2 cycles into a 4-cycle count, then release with the raw input still high
//     -> rise takes a full 6 edges from release.
//  6. SENSOR_LATCH_EN, A step high then raw low -> oTa stays 1 until iClrA.
//     iClrA in the same cycle as a new deb rise -> latch stays 1.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared traffic-light encodings and sensor conditioning defaults.
// Imported by the sensor conditioner, controller and display stage.
package tl_pkg;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_t;

  typedef enum logic {
    NO_CAR = 1'b0,
    CAR    = 1'b1
  } sensor_t;

endpackage

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, stability counter,
// debounced level and a one-cycle change pulse.
module sensor_debounce
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic chg
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      deb <= 1'b0;
      chg <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      chg <= 1'b0;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= s2;
        cnt <= '0;
        chg <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_sensor_cond.sv
// Conditions the street A/B car sensors into clean Ta/Tb levels.
// Define SENSOR_LATCH_EN to hold requests until iClrA/iClrB.
module traffic_sensor_cond
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic CLK,
  input  logic Reset,
  input  logic iTa_raw,
  input  logic iTb_raw,
  input  logic iClrA,
  input  logic iClrB,
  output logic oTa,
  output logic oTb,
  output logic oTa_chg,
  output logic oTb_chg
);

  logic deb_a;
  logic deb_b;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_a (
    .clk(CLK),
    .rst(Reset),
    .raw(iTa_raw),
    .deb(deb_a),
    .chg(oTa_chg)
  );

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_deb_b (
    .clk(CLK),
    .rst(Reset),
    .raw(iTb_raw),
    .deb(deb_b),
    .chg(oTb_chg)
  );

`ifdef SENSOR_LATCH_EN
  logic latch_a;
  logic latch_b;

  // chg with deb high marks a fresh rise; set beats clear
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      latch_a <= 1'b0;
      latch_b <= 1'b0;
    end else begin
      if (oTa_chg && deb_a) latch_a <= 1'b1;
      else if (iClrA)       latch_a <= 1'b0;
      if (oTb_chg && deb_b) latch_b <= 1'b1;
      else if (iClrB)       latch_b <= 1'b0;
    end
  end

  assign oTa = deb_a | latch_a;
  assign oTb = deb_b | latch_b;
`else
  logic unused_clr;
  assign unused_clr = iClrA ^ iClrB;

  assign oTa = deb_a;
  assign oTb = deb_b;
`endif

endmodule
